br_cond_dispatch: RTL

- Consumer end of the compare-result path.
- Accepts the 1-bit result of an integer-compare operator (eq/ne/ugt/…/sle) through a valid/ready handshake.
- Dispatches a start to exactly one of two successor basic-block controllers: true target or false target.
- Sits between the compare datapath and the block-sequencing logic of generated hardware; implements LLVM conditional "br" semantics with per-direction statistics counters.

---
 rtl/br_cond_dispatch.sv | 122 ++++++++++++
 1 files changed

// File: rtl/br_cond_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : br_cond_dispatch
// Purpose  : Consumer end of the compare-result path. Accepts a 1-bit compare
//            result over a valid/ready handshake and dispatches a start to
//            exactly one of two successor block controllers (true / false
//            target), implementing conditional-branch semantics. Keeps
//            saturating per-direction dispatch counters.
// Ports    : clk_i, reset_i        - clock, synchronous active-high reset
//            enable_i              - predecessor block active (gates accept)
//            cond_valid_i, cond_i  - compare result in, 1 = true target
//            cond_ready_o          - branch can accept a condition
//            succ_t_start_o/_ready_i - start handshake to true target
//            succ_f_start_o/_ready_i - start handshake to false target
//            busy_o                - a decision is held, not yet dispatched
//            last_taken_o          - direction of last dispatched branch
//            taken_cnt_o, not_taken_cnt_o - saturating dispatch counters
// Revision : 1.0 - initial release
// ============================================================================
module br_cond_dispatch #(
  parameter bit          ParamUnconditional = 1'b0,
  parameter int unsigned ParamCntWidth      = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     cond_valid_i,
  input  logic                     cond_i,
  output logic                     cond_ready_o,
  output logic                     succ_t_start_o,
  input  logic                     succ_t_ready_i,
  output logic                     succ_f_start_o,
  input  logic                     succ_f_ready_i,
  output logic                     busy_o,
  output logic                     last_taken_o,
  output logic [ParamCntWidth-1:0] taken_cnt_o,
  output logic [ParamCntWidth-1:0] not_taken_cnt_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam logic [ParamCntWidth-1:0] CNT_MAX = '1;
  localparam logic [ParamCntWidth-1:0] CNT_ONE = ParamCntWidth'(1);

  state_e                   state_q, state_d;
  logic                     dec_q, dec_d;
  logic                     last_taken_q, last_taken_d;
  logic [ParamCntWidth-1:0] taken_cnt_q, taken_cnt_d;
  logic [ParamCntWidth-1:0] not_taken_cnt_q, not_taken_cnt_d;

  logic w_accept;
  logic w_handshake;

  // Reset is folded into ready so nothing is accepted on a reset cycle.
  assign cond_ready_o = (state_q == ST_IDLE) && enable_i && !reset_i;
  assign w_accept     = cond_valid_i && cond_ready_o;

  // Only the selected target's ready completes the dispatch.
  assign w_handshake  = (state_q == ST_ISSUE) &&
                        (dec_q ? succ_t_ready_i : succ_f_ready_i);

  always_comb begin
    state_d         = state_q;
    dec_d           = dec_q;
    last_taken_d    = last_taken_q;
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          dec_d   = ParamUnconditional ? 1'b1 : cond_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // enable_i is deliberately not consulted: an issued start always runs
        // to its handshake.
        if (w_handshake) begin
          last_taken_d = dec_q;
          if (dec_q) begin
            if (taken_cnt_q != CNT_MAX) taken_cnt_d = taken_cnt_q + CNT_ONE;
          end else begin
            if (not_taken_cnt_q != CNT_MAX) not_taken_cnt_d = not_taken_cnt_q + CNT_ONE;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      dec_q           <= 1'b0;
      last_taken_q    <= 1'b0;
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      dec_q           <= dec_d;
      last_taken_q    <= last_taken_d;
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  // Starts are pure functions of registered state, so they are glitch-free
  // and mutually exclusive by construction.
  assign busy_o          = (state_q == ST_ISSUE);
  assign succ_t_start_o  = (state_q == ST_ISSUE) &&  dec_q;
  assign succ_f_start_o  = (state_q == ST_ISSUE) && !dec_q;
  assign last_taken_o    = last_taken_q;
  assign taken_cnt_o     = taken_cnt_q;
  assign not_taken_cnt_o = not_taken_cnt_q;

endmodule
`default_nettype wire
